// File: rtl/lc3_fetch_pkg.sv
// Shared opcodes, FSM state type and offset sign-extension for the LC-3 fetch controller.
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // short_off selects the 9-bit BR offset, otherwise the full 11-bit JSR offset.
  function automatic logic [31:0] sext(input logic [10:0] off, input logic short_off);
    return short_off ? {{23{off[8]}}, off[8:0]} : {{21{off[10]}}, off};
  endfunction

endpackage

// File: rtl/lc3_next_pc.sv
// Combinational next-PC and link-address selection from the previous instruction's control flow.
module lc3_next_pc
  import lc3_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              first,
  input  logic [3:0]        op_code,
  input  logic [10:0]       offset,
  input  logic              jsr_imm,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_en
);

  logic [ADDR_W-1:0] inc;

  assign inc       = pc + ADDR_W'(1);
  assign link_addr = inc;

  always_comb begin
    target  = inc;
    link_en = 1'b0;
    // The very first fetch after reset fetches from the reset PC itself.
    if (first) begin
      target = pc;
    end else begin
      case (op_code)
        OP_BR: begin
          if (|(br_nzp & result_nzp)) target = inc + ADDR_W'(sext(offset, 1'b1));
        end
        OP_JMP: target = reg_in;
        OP_JSR: begin
          target  = jsr_imm ? inc + ADDR_W'(sext(offset, 1'b0)) : reg_in;
          link_en = 1'b1;
        end
        default: target = inc;
      endcase
    end
  end

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 fetch controller: next-PC selection and instruction-memory read with ready/timeout handshake.
//   state   | meaning
//   IDLE    | waiting for fetch_start; addr_out holds last address
//   REQ     | mem_req high, waiting for mem_ready or timeout
module lc3_fetch_ctrl
  import lc3_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic              jsr_imm,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              busy
);

  localparam int              CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] pc_d, addr_d, link_d;
  logic              req_d, link_we_d, done_d, err_d;
  logic [ADDR_W-1:0] target, link_calc;
  logic              link_en;

  lc3_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc         (pc),
    .first      (first_q),
    .op_code    (opCode_in),
    .offset     (offset_in),
    .jsr_imm    (jsr_imm),
    .reg_in     (reg_in),
    .br_nzp     (br_nzp),
    .result_nzp (result_nzp),
    .target     (target),
    .link_addr  (link_calc),
    .link_en    (link_en)
  );

  assign wea_out = 1'b0;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    pc_d      = pc;
    addr_d    = addr_out;
    link_d    = link_addr;
    req_d     = mem_req;
    link_we_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          pc_d    = target;
          addr_d  = target;
          req_d   = 1'b1;
          cnt_d   = '0;
          first_d = 1'b0;
          state_d = ST_REQ;
          if (link_en) begin
            link_d    = link_calc;
            link_we_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // Ready takes priority over a timeout landing on the same edge.
        if (mem_ready) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      pc         <= RESET_PC;
      addr_out   <= '0;
      link_addr  <= '0;
      mem_req    <= 1'b0;
      link_we    <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      pc         <= pc_d;
      addr_out   <= addr_d;
      link_addr  <= link_d;
      mem_req    <= req_d;
      link_we    <= link_we_d;
      fetch_done <= done_d;
      fetch_err  <= err_d;
    end
  end

endmodule

// File: doc/lc3_fetch_ctrl.md
# lc3_fetch_ctrl

Parametrised successor to the LC-3 fetch unit. Computes the next PC from the control-flow outcome of the previous instruction (BR, JMP/RET, JSR/JSRR, sequential), then issues a read to instruction memory with a ready/timeout handshake. Adds a link address for JSR and a busy/done/error status. Sits between the decode/execute stage and the instruction memory port.

## Interface
- ADDR_W, 16, address and PC width (≥ 11)
- RESET_PC, 0, PC value loaded at reset
- WAIT_MAX, 8, maximum REQ cycles without mem_ready before error (≥ 1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_start  in  1  request next fetch; sampled only in IDLE
- opCode_in  in  4  opcode of the previous instruction
- offset_in  in  11  PC offset; BR uses [8:0], JSR uses [10:0]
- jsr_imm  in  1  JSR (1, PC-relative) vs JSRR (0, register)
- reg_in  in  ADDR_W  base register value for JMP/JSRR
- br_nzp  in  3  BR condition mask
- result_nzp  in  3  current condition codes
- mem_ready  in  1  memory has returned the word
- addr_out  out  ADDR_W  memory address
- wea_out  out  1  memory write enable; always 0
- mem_req  out  1  read request, held until ready or timeout
- pc  out  ADDR_W  address of the instruction being fetched
- link_addr  out  ADDR_W  return address for JSR/JSRR
- link_we  out  1  one-cycle pulse: write link_addr to R7
- fetch_done  out  1  one-cycle pulse: fetch completed
- fetch_err  out  1  one-cycle pulse: timeout
- busy  out  1  state != IDLE (combinational)

## Operation
- States: IDLE, REQ.
- Reset: state IDLE, pc = RESET_PC, addr_out = 0, wea_out = 0, mem_req = 0, link_addr = 0, link_we = 0, fetch_done = 0, fetch_err = 0, first flag = 1, wait counter = 0.
- Target (inc = pc + 1, all arithmetic mod 2^ADDR_W, offsets sign-extended):
  - first flag set: target = pc, inputs ignored, flag cleared.
  - 0000 BR: taken iff |(br_nzp & result_nzp) -> inc + sext(offset_in[8:0]); else inc. br_nzp = 000 is never taken.
  - 1100 JMP/RET: reg_in.
  - 0100 JSR/JSRR: jsr_imm ? inc + sext(offset_in[10:0]) : reg_in. link_addr <= inc, link_we pulses.
  - any other opcode: inc.
- IDLE, fetch_start = 1: pc <= target, addr_out <= target, mem_req <= 1, counter <= 0, go to REQ.
- REQ: if mem_ready, then mem_req <= 0, fetch_done pulse, go to IDLE. Otherwise counter++. When counter reaches WAIT_MAX-1 without ready, fetch_err pulses, mem_req <= 0, go to IDLE. pc keeps the target.
- fetch_start in REQ is ignored; there is no queueing.
- addr_out holds its last value in IDLE.

## Timing
- fetch_start edge -> pc, addr_out, mem_req, link_* valid after the same edge (1-cycle latency).
- mem_ready sampled in REQ. If it is high on the first REQ edge, fetch_done is high in the second cycle after fetch_start. mem_ready in IDLE is ignored.
- Timeout: fetch_err pulses in the cycle after the WAIT_MAX-th REQ edge without ready.
- mem_ready and the timeout on the same edge: ready wins, no error.
- Reset mid-REQ: mem_req drops asynchronously, all outputs return to reset values, and the first flag is set again.

## Structure
- lc3_fetch_pkg: OP_BR, OP_JSR, OP_JMP constants, state enum, and an sext helper.
- One sub-module, lc3_next_pc: combinational target and link computation, parametrised by ADDR_W.

## Test plan
- Reset held for 5 cycles, fetch_start = 0 -> addr_out = 0, wea_out = 0, pc = 0, mem_req = 0, busy = 0.
- First fetch with opcode 0001, mem_ready after 2 cycles -> addr_out = 0x0000, mem_req held 2 cycles, then fetch_done pulse. Next fetch with 0001 -> pc = 0x0001.
- BRp from pc = 0x3000, br_nzp = 001, offset 9'h1FE: result_nzp = 001 -> pc = 0x2FFF; result_nzp = 010 -> pc = 0x3001.
- From pc = 0x3000: JSR with jsr_imm = 1, offset 11'h010 -> pc = 0x3011, link_addr = 0x3001, one link_we pulse. Then JMP with reg_in = 0x4000 -> pc = 0x4000, no link_we.
- Wrap: pc = 0xFFFF, opcode 0001 -> pc = 0x0000. BR taken from 0xFFFF with offset +2 -> pc = 0x0002.
- Timeout and reset:
  - WAIT_MAX = 4, mem_ready held 0 -> fetch_err pulses once, mem_req drops, busy goes to 0.
  - fetch_start pulsed during REQ -> no effect.
  - rst_n asserted mid-REQ -> mem_req = 0 immediately, pc = RESET_PC.
